// File: rtl/frodo_ctrl_pkg.sv
// Shared types and constants for the FrodoKEM multiply sequencer.
package frodo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int unsigned S_A_LANES = 8;
  localparam int unsigned L_A_LANES = 2;
  localparam int unsigned L_B_LANES = 4;

  localparam int unsigned A_LANE_W = 3;
  localparam int unsigned B_LANE_W = 2;

  localparam logic MODE_S = 1'b1;
  localparam logic MODE_L = 1'b0;

  // k_len must be a whole number of A words (S) or B words (L) per group
  function automatic logic k_len_legal(input logic mode, input logic [2:0] k_lsb);
    if (mode == MODE_S) return k_lsb == 3'd0;
    return k_lsb[1:0] == 2'd0;
  endfunction

endpackage

// File: rtl/mul_addr_gen.sv
// Lane counters, prefetch read-enable decode and A/B address registers.
// All control inputs describe the upcoming cycle, so every output is a flop.
import frodo_ctrl_pkg::*;

module mul_addr_gen #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode,
  input  logic              load,
  input  logic              run,
  input  logic              group_first,
  input  logic              last_step,
  input  logic              last_mac,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              a_ren,
  output logic [ADDR_W-1:0] a_addr,
  output logic              b_ren,
  output logic [ADDR_W-1:0] b_addr
);

  logic [A_LANE_W-1:0] a_lane, a_lane_n, a_max;
  logic [B_LANE_W-1:0] b_lane, b_lane_n;
  logic [ADDR_W-1:0]   a_base_q, a_base_q_n, a_addr_n, b_addr_n;
  logic                a_ren_n, b_ren_n, b_last;

  // Lane tracking and prefetch decode for the upcoming cycle
  always_comb begin
    a_max      = (mode == MODE_S) ? A_LANE_W'(S_A_LANES - 1) : A_LANE_W'(L_A_LANES - 1);
    a_lane_n   = '0;
    b_lane_n   = '0;
    a_base_q_n = a_base_q;
    if (run && !group_first) begin
      a_lane_n = (a_lane == a_max) ? '0 : a_lane + A_LANE_W'(1);
      b_lane_n = (b_lane == B_LANE_W'(L_B_LANES - 1)) ? '0 : b_lane + B_LANE_W'(1);
    end
    b_last  = (mode == MODE_S) || (b_lane_n == B_LANE_W'(L_B_LANES - 1));
    a_ren_n = load || (run && (a_lane_n == a_max) && !last_mac);
    b_ren_n = load || (run && b_last && !last_mac);

    a_addr_n = a_addr;
    b_addr_n = b_addr;
    if (load) begin
      a_base_q_n = a_base;
      a_addr_n   = a_base;
      b_addr_n   = b_base;
    end else begin
      // A restarts at the latched base for the next group; B never restarts
      if (a_ren_n) a_addr_n = last_step ? a_base_q : a_addr + ADDR_W'(1);
      if (b_ren_n) b_addr_n = b_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_lane   <= '0;
      b_lane   <= '0;
      a_base_q <= '0;
      a_ren    <= 1'b0;
      b_ren    <= 1'b0;
      a_addr   <= '0;
      b_addr   <= '0;
    end else begin
      a_lane   <= a_lane_n;
      b_lane   <= b_lane_n;
      a_base_q <= a_base_q_n;
      a_ren    <= a_ren_n;
      b_ren    <= b_ren_n;
      a_addr   <= a_addr_n;
      b_addr   <= b_addr_n;
    end
  end

endmodule

// File: rtl/frodo_mul_ctrl.sv
// Sequencer for the FrodoKEM matrix-multiply datapath: walks K steps over G groups
// and drives memory reads, data-prep strobes and MAC control, all from flops.
import frodo_ctrl_pkg::*;

module frodo_mul_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned K_W    = 11,
  parameter int unsigned G_W    = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic [K_W-1:0]    k_len,
  input  logic [G_W-1:0]    g_cnt,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              a_ren,
  output logic              b_ren,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              start_pos,
  output logic              done,
  output logic              short_data_mode,
  output logic              short_bia_add,
  output logic              long_bia_add,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              acc_wr,
  output logic              busy,
  output logic              cfg_err
);

  state_t         state, state_n;
  logic [K_W-1:0] step, step_n, k_last;
  logic [G_W-1:0] grp, grp_n, g_last;
  logic           mode_q, mode_n;
  logic           legal, accept, last_step, last_grp;

  logic load_n, run_n, group_first_n, last_step_n, last_mac_n;
  logic start_pos_n, done_n, sba_n, lba_n, mac_en_n, mac_clr_n, acc_wr_n, busy_n, cfg_err_n;

  // State, counters and command latches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      step   <= '0;
      grp    <= '0;
      mode_q <= MODE_L;
      k_last <= '0;
      g_last <= '0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      grp    <= grp_n;
      mode_q <= mode_n;
      if (accept) begin
        k_last <= k_len - K_W'(1);
        g_last <= g_cnt - G_W'(1);
      end
    end
  end

  // Next state and step/group counters
  always_comb begin
    state_n   = state;
    step_n    = step;
    grp_n     = grp;
    mode_n    = mode_q;
    legal     = k_len_legal(mode, k_len[2:0]);
    accept    = (state == IDLE) && start && legal;
    last_step = (step == k_last);
    last_grp  = (grp == g_last);
    case (state)
      IDLE: begin
        step_n = '0;
        grp_n  = '0;
        if (accept) begin
          mode_n  = mode;
          state_n = (k_len == '0 || g_cnt == '0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        step_n  = '0;
        grp_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        if (last_step) begin
          step_n = '0;
          grp_n  = grp + G_W'(1);
          if (last_grp) state_n = FIN;
        end else begin
          step_n = step + K_W'(1);
        end
      end
      FIN: begin
        step_n  = '0;
        grp_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode for the upcoming cycle; the flops below present it
  always_comb begin
    load_n        = (state_n == LOAD);
    run_n         = (state_n == RUN);
    group_first_n = run_n && (step_n == '0);
    last_step_n   = run_n && (step_n == k_last);
    last_mac_n    = last_step_n && (grp_n == g_last);
    start_pos_n   = load_n;
    done_n        = (state_n == FIN);
    busy_n        = (state_n != IDLE);
    mac_en_n      = run_n;
    sba_n         = run_n;
    lba_n         = run_n && (mode_n == MODE_L);
    mac_clr_n     = group_first_n;
    acc_wr_n      = (state == RUN) && last_step;
    cfg_err_n     = (state == IDLE) && start && !legal;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_pos     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      mac_en        <= 1'b0;
      short_bia_add <= 1'b0;
      long_bia_add  <= 1'b0;
      mac_clr       <= 1'b0;
      acc_wr        <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      start_pos     <= start_pos_n;
      done          <= done_n;
      busy          <= busy_n;
      mac_en        <= mac_en_n;
      short_bia_add <= sba_n;
      long_bia_add  <= lba_n;
      mac_clr       <= mac_clr_n;
      acc_wr        <= acc_wr_n;
      cfg_err       <= cfg_err_n;
    end
  end

  assign short_data_mode = mode_q;

  mul_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rstn       (rstn),
    .mode       (mode_n),
    .load       (load_n),
    .run        (run_n),
    .group_first(group_first_n),
    .last_step  (last_step_n),
    .last_mac   (last_mac_n),
    .a_base     (a_base),
    .b_base     (b_base),
    .a_ren      (a_ren),
    .a_addr     (a_addr),
    .b_ren      (b_ren),
    .b_addr     (b_addr)
  );

endmodule

// File: tb/tb_frodo_mul_ctrl.sv
// Scoreboard bench for frodo_mul_ctrl: each command pushes its expected event
// timeline, and a negedge monitor pops and compares as the DUT produces events.
module tb_frodo_mul_ctrl;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned K_W    = 11;
  localparam int unsigned G_W    = 10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [K_W-1:0]    k_len = '0;
  logic [G_W-1:0]    g_cnt = '0;
  logic [ADDR_W-1:0] a_base = '0;
  logic [ADDR_W-1:0] b_base = '0;
  logic              a_ren, b_ren, start_pos, done, short_data_mode;
  logic              short_bia_add, long_bia_add, mac_en, mac_clr, acc_wr, busy, cfg_err;
  logic [ADDR_W-1:0] a_addr, b_addr;

  frodo_mul_ctrl #(.ADDR_W(ADDR_W), .K_W(K_W), .G_W(G_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .k_len(k_len), .g_cnt(g_cnt),
    .a_base(a_base), .b_base(b_base), .a_ren(a_ren), .b_ren(b_ren), .a_addr(a_addr),
    .b_addr(b_addr), .start_pos(start_pos), .done(done), .short_data_mode(short_data_mode),
    .short_bia_add(short_bia_add), .long_bia_add(long_bia_add), .mac_en(mac_en),
    .mac_clr(mac_clr), .acc_wr(acc_wr), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  rd_t qa[$], qb[$];
  int  q_acc[$], q_done[$], q_sp[$], q_err[$], q_clr[$];
  int  n_vec = 0, n_err = 0;
  int  cnt_mac = 0, cnt_sb = 0, cnt_lb = 0, cnt_busy = 0;
  rd_t ea;
  int  ei;

  function automatic int pending();
    return qa.size() + qb.size() + q_acc.size() + q_done.size() + q_sp.size() + q_err.size() + q_clr.size();
  endfunction

  function automatic void flush();
    qa.delete(); qb.delete(); q_acc.delete(); q_done.delete();
    q_sp.delete(); q_err.delete(); q_clr.delete();
  endfunction

  // Expected event timeline derived from the command, cycle 0 = start sampled
  task automatic model_cmd(input logic m, input int k, input int g, input logic [ADDR_W-1:0] ab,
                           input logic [ADDR_W-1:0] bb, input int t0, output int t_end);
    int al, bl, kg, kk;
    rd_t r;
    al = m ? 8 : 2;
    bl = m ? 1 : 4;
    if ((m && (k % 8) != 0) || (!m && (k % 4) != 0)) begin
      q_err.push_back(t0 + 1);
      t_end = t0 + 2;
      return;
    end
    if (k == 0 || g == 0) begin
      q_done.push_back(t0 + 1);
      t_end = t0 + 2;
      return;
    end
    kg = k * g;
    q_sp.push_back(t0 + 1);
    r.cyc = t0 + 1; r.addr = ab; qa.push_back(r);
    r.addr = bb; qb.push_back(r);
    for (int mi = 0; mi < kg - 1; mi++) begin
      kk = mi % k;
      r.cyc = t0 + 2 + mi;
      if ((kk % al) == al - 1) begin
        r.addr = (kk == k - 1) ? ab : ADDR_W'(ab + (kk + 1) / al);
        qa.push_back(r);
      end
      if ((kk % bl) == bl - 1) begin
        r.addr = ADDR_W'(bb + (mi + 1) / bl);
        qb.push_back(r);
      end
    end
    for (int gi = 0; gi < g; gi++) begin
      q_clr.push_back(t0 + 2 + gi * k);
      q_acc.push_back(t0 + 2 + k * (gi + 1));
    end
    q_done.push_back(t0 + 2 + kg);
    t_end = t0 + 3 + kg;
  endtask

  // Called just after a rising edge; returns one cycle later
  task automatic issue(input logic m, input int k, input int g, input logic [ADDR_W-1:0] ab,
                       input logic [ADDR_W-1:0] bb, output int t0, output int t_end);
    mode = m; k_len = K_W'(k); g_cnt = G_W'(g); a_base = ab; b_base = bb; start = 1'b1;
    t0 = cyc;
    model_cmd(m, k, g, ab, bb, t0, t_end);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_counts();
    cnt_mac = 0; cnt_sb = 0; cnt_lb = 0; cnt_busy = 0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (mac_en) cnt_mac++;
      if (short_bia_add) cnt_sb++;
      if (long_bia_add) cnt_lb++;
      if (busy) cnt_busy++;
      if (a_ren) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_err++;
          $display("FAIL a_read: unexpected read addr=%h at cyc %0d, required none", a_addr, cyc);
        end else begin
          ea = qa.pop_front();
          if (ea.cyc != cyc || ea.addr !== a_addr) begin
            n_err++;
            $display("FAIL a_read: got addr=%h cyc=%0d, required addr=%h cyc=%0d", a_addr, cyc, ea.addr, ea.cyc);
          end
        end
      end
      if (b_ren) begin
        n_vec++;
        if (qb.size() == 0) begin
          n_err++;
          $display("FAIL b_read: unexpected read addr=%h at cyc %0d, required none", b_addr, cyc);
        end else begin
          ea = qb.pop_front();
          if (ea.cyc != cyc || ea.addr !== b_addr) begin
            n_err++;
            $display("FAIL b_read: got addr=%h cyc=%0d, required addr=%h cyc=%0d", b_addr, cyc, ea.addr, ea.cyc);
          end
        end
      end
      if (acc_wr) begin
        n_vec++;
        if (q_acc.size() != 0) ei = q_acc.pop_front(); else ei = -1;
        if (ei != cyc) begin
          n_err++;
          $display("FAIL acc_wr: pulse at cyc %0d, required cyc %0d (-1 = none)", cyc, ei);
        end
      end
      if (done) begin
        n_vec++;
        if (q_done.size() != 0) ei = q_done.pop_front(); else ei = -1;
        if (ei != cyc) begin
          n_err++;
          $display("FAIL done: pulse at cyc %0d, required cyc %0d (-1 = none)", cyc, ei);
        end
      end
      if (start_pos) begin
        n_vec++;
        if (q_sp.size() != 0) ei = q_sp.pop_front(); else ei = -1;
        if (ei != cyc) begin
          n_err++;
          $display("FAIL start_pos: pulse at cyc %0d, required cyc %0d (-1 = none)", cyc, ei);
        end
      end
      if (cfg_err) begin
        n_vec++;
        if (q_err.size() != 0) ei = q_err.pop_front(); else ei = -1;
        if (ei != cyc) begin
          n_err++;
          $display("FAIL cfg_err: pulse at cyc %0d, required cyc %0d (-1 = none)", cyc, ei);
        end
      end
      if (mac_clr) begin
        n_vec++;
        if (q_clr.size() != 0) ei = q_clr.pop_front(); else ei = -1;
        if (ei != cyc) begin
          n_err++;
          $display("FAIL mac_clr: pulse at cyc %0d, required cyc %0d (-1 = none)", cyc, ei);
        end
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({a_ren, b_ren, start_pos, done, short_data_mode, short_bia_add, long_bia_add,
         mac_en, mac_clr, acc_wr, busy, cfg_err} !== 12'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, required all 0", {a_ren, b_ren, start_pos, done,
               short_data_mode, short_bia_add, long_bia_add, mac_en, mac_clr, acc_wr, busy, cfg_err});
    end
    n_vec++;
    if (a_addr !== '0 || b_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addr: got a=%h b=%h, required 0 0", a_addr, b_addr);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_s_mode();
    int t0, te;
    clear_counts();
    issue(1'b1, 16, 2, 14'h0010, 14'h0100, t0, te);
    n_vec++;
    if (short_data_mode !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL s_mode_load: got sdm=%b busy=%b, required 1 1", short_data_mode, busy);
    end
    wait_until(te);
    n_vec++;
    if (pending() != 0) begin
      n_err++;
      $display("FAIL s_mode_pending: %0d events not seen, required 0", pending());
    end
    n_vec++;
    if (cnt_sb != 32 || cnt_lb != 0 || cnt_mac != 32 || cnt_busy != 34) begin
      n_err++;
      $display("FAIL s_mode_counts: got sba=%0d lba=%0d mac=%0d busy=%0d, required 32 0 32 34",
               cnt_sb, cnt_lb, cnt_mac, cnt_busy);
    end
  endtask

  task automatic test_l_mode();
    int t0, te;
    clear_counts();
    issue(1'b0, 8, 1, 14'h0000, 14'h0040, t0, te);
    n_vec++;
    if (short_data_mode !== 1'b0) begin
      n_err++;
      $display("FAIL l_mode_sdm: got %b, required 0", short_data_mode);
    end
    wait_until(te);
    n_vec++;
    if (pending() != 0) begin
      n_err++;
      $display("FAIL l_mode_pending: %0d events not seen, required 0", pending());
    end
    n_vec++;
    if (cnt_lb != 8 || cnt_sb != 8 || cnt_mac != 8) begin
      n_err++;
      $display("FAIL l_mode_counts: got lba=%0d sba=%0d mac=%0d, required 8 8 8", cnt_lb, cnt_sb, cnt_mac);
    end
  endtask

  task automatic test_cfg_err();
    int t0, te;
    clear_counts();
    issue(1'b1, 12, 1, 14'h0005, 14'h0006, t0, te);
    wait_until(te + 2);
    issue(1'b0, 6, 2, 14'h0005, 14'h0006, t0, te);
    wait_until(te + 2);
    n_vec++;
    if (pending() != 0 || cnt_busy != 0 || cnt_mac != 0) begin
      n_err++;
      $display("FAIL cfg_err_quiet: got pending=%0d busy=%0d mac=%0d, required 0 0 0", pending(), cnt_busy, cnt_mac);
    end
  endtask

  task automatic test_zero_len();
    int t0, te;
    clear_counts();
    issue(1'b1, 16, 0, 14'h0011, 14'h0022, t0, te);
    wait_until(te);
    issue(1'b0, 0, 3, 14'h0011, 14'h0022, t0, te);
    wait_until(te + 1);
    n_vec++;
    if (pending() != 0 || cnt_mac != 0 || cnt_busy != 2) begin
      n_err++;
      $display("FAIL zero_len: got pending=%0d mac=%0d busy=%0d, required 0 0 2", pending(), cnt_mac, cnt_busy);
    end
  endtask

  task automatic test_back_to_back();
    int t0, te, t1, te1;
    clear_counts();
    issue(1'b1, 8, 2, 14'h0050, 14'h0500, t0, te);
    wait_until(t0 + 5);
    // Spurious command mid-RUN; the changed a_base must not disturb the group restart
    mode = 1'b0; k_len = K_W'(4); g_cnt = G_W'(1); a_base = 14'h0007; b_base = 14'h0009; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(te);
    issue(1'b0, 4, 3, 14'h0060, 14'h0600, t1, te1);
    n_vec++;
    if (t1 != te || start_pos !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: start at cyc %0d start_pos=%b, required cyc %0d start_pos=1", t1, start_pos, te);
    end
    wait_until(te1);
    n_vec++;
    if (pending() != 0 || cnt_mac != 28 || cnt_lb != 12) begin
      n_err++;
      $display("FAIL b2b_done: got pending=%0d mac=%0d lba=%0d, required 0 28 12", pending(), cnt_mac, cnt_lb);
    end
  endtask

  task automatic test_random();
    int t0, te, k, g, exp_mac, exp_lb;
    logic m;
    clear_counts();
    exp_mac = 0; exp_lb = 0;
    issue(1'b0, 8, 2, 14'h3fff, 14'h3fff, t0, te);
    exp_mac += 16; exp_lb += 16;
    wait_until(te);
    for (int i = 0; i < 5; i++) begin
      m = 1'($urandom_range(0, 1));
      k = (m ? 8 : 4) * int'($urandom_range(1, 3));
      g = int'($urandom_range(1, 3));
      issue(m, k, g, ADDR_W'($urandom), ADDR_W'($urandom), t0, te);
      exp_mac += k * g;
      if (!m) exp_lb += k * g;
      wait_until(te);
    end
    n_vec++;
    if (pending() != 0 || cnt_mac != exp_mac || cnt_lb != exp_lb) begin
      n_err++;
      $display("FAIL random: got pending=%0d mac=%0d lba=%0d, required 0 %0d %0d", pending(), cnt_mac, cnt_lb, exp_mac, exp_lb);
    end
  endtask

  task automatic test_reset_mid();
    int t0, te;
    issue(1'b1, 16, 2, 14'h0020, 14'h0200, t0, te);
    wait_until(t0 + 10);
    #2;
    n_vec++;
    if (busy !== 1'b1 || mac_en !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: got busy=%b mac_en=%b, required 1 1", busy, mac_en);
    end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({a_ren, b_ren, start_pos, done, short_data_mode, short_bia_add, long_bia_add,
         mac_en, mac_clr, acc_wr, busy, cfg_err, a_addr, b_addr} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: outputs not cleared, busy=%b mac_en=%b a=%h b=%h, required all 0",
               busy, mac_en, a_addr, b_addr);
    end
    flush();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_counts();
    issue(1'b0, 8, 2, 14'h0030, 14'h0300, t0, te);
    wait_until(te);
    n_vec++;
    if (pending() != 0 || cnt_sb != 16 || cnt_lb != 16) begin
      n_err++;
      $display("FAIL mid_recover: got pending=%0d sba=%0d lba=%0d, required 0 16 16", pending(), cnt_sb, cnt_lb);
    end
  endtask

  initial begin
    test_reset();
    test_s_mode();
    test_l_mode();
    test_cfg_err();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
